robo_step_sequencer: RTL and testbench

Controller that runs the wall-following robot FSM (Robo) against a 20x20 map for a bounded number of moves. Per move it reads the map to derive the head/left sensors, pulses the robot step enable, samples avancar/girar, and updates the tracked pose (row, col, orientation). It flags completion and anomalies (off-map, wall collision, illegal robot output). It sits between the map ROM and the Robo core and replaces bench-side sequencing in the synthesizable demo.

---
 rtl/robo_step_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_robo_step_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/robo_step_sequencer.sv
// Step sequencer for the wall-following Robo FSM: sensing, step pulse, pose tracking on a MAP_SIZE map.
// Optional LOOP_DETECT_EN: finish early when the robot returns to its starting pose.
module robo_step_sequencer #(
    parameter int MAP_SIZE = 20,
    parameter int POS_W    = 5,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [POS_W-1:0] init_row,
    input  logic [POS_W-1:0] init_col,
    input  logic [1:0]       init_dir,
    input  logic [CNT_W-1:0] max_moves,
    output logic [POS_W-1:0] map_row,
    output logic [POS_W-1:0] map_col,
    input  logic             map_wall,
    output logic             head,
    output logic             left,
    output logic             robot_step,
    input  logic             avancar,
    input  logic             girar,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col,
    output logic [1:0]       dir,
    output logic [CNT_W-1:0] moves,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SENSE_H, S_SENSE_L, S_DRIVE, S_SAMPLE, S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        DIR_N = 2'b00, DIR_S = 2'b01, DIR_L = 2'b10, DIR_O = 2'b11
    } dir_t;

    localparam logic [POS_W:0] EDGE_HI = (POS_W+1)'(MAP_SIZE);

    state_t           state_q, state_d;
    logic [POS_W-1:0] row_q, row_d, col_q, col_d;
    dir_t             dir_q, dir_d;
    logic [CNT_W-1:0] max_q, max_d, moves_q, moves_d;
    logic             head_q, head_d, left_q, left_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
`ifdef LOOP_DETECT_EN
    logic [POS_W-1:0] init_row_q, init_row_d, init_col_q, init_col_d;
    dir_t             init_dir_q, init_dir_d;
`endif

    logic [POS_W:0] r_x, c_x, hr, hc, lr, lc, q_r, q_c;
    logic           q_en, q_off, sensor;

    // Extra MSB lets neighbours of edge cells land on 0 or MAP_SIZE+1 without wrapping.
    function automatic logic is_off(input logic [POS_W:0] v);
        return (v == '0) || (v > EDGE_HI);
    endfunction

    function automatic logic [POS_W-1:0] clip(input logic [POS_W:0] v);
        if (v == '0)
            return POS_W'(1);
        else if (v > EDGE_HI)
            return POS_W'(MAP_SIZE);
        else
            return v[POS_W-1:0];
    endfunction

    always_comb begin
        r_x = {1'b0, row_q};
        c_x = {1'b0, col_q};
        hr  = r_x;
        hc  = c_x;
        lr  = r_x;
        lc  = c_x;
        case (dir_q)
            DIR_N: begin hr = r_x - 1'b1; lc = c_x - 1'b1; end
            DIR_S: begin hr = r_x + 1'b1; lc = c_x + 1'b1; end
            DIR_L: begin hc = c_x + 1'b1; lr = r_x - 1'b1; end
            DIR_O: begin hc = c_x - 1'b1; lr = r_x + 1'b1; end
            default: ;
        endcase

        q_en = 1'b1;
        q_r  = r_x;
        q_c  = c_x;
        case (state_q)
            S_CHECK:   begin q_r = r_x; q_c = c_x; end
            S_SENSE_H: begin q_r = hr;  q_c = hc;  end
            S_SENSE_L: begin q_r = lr;  q_c = lc;  end
            default:   begin q_en = 1'b0; q_r = '0; q_c = '0; end
        endcase

        q_off   = is_off(q_r) || is_off(q_c);
        sensor  = q_off || map_wall;
        map_row = q_en ? clip(q_r) : '0;
        map_col = q_en ? clip(q_c) : '0;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dir_d   = dir_q;
        max_d   = max_q;
        moves_d = moves_q;
        head_d  = head_q;
        left_d  = left_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef LOOP_DETECT_EN
        init_row_d = init_row_q;
        init_col_d = init_col_q;
        init_dir_d = init_dir_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d   = init_row;
                    col_d   = init_col;
                    dir_d   = dir_t'(init_dir);
                    max_d   = max_moves;
                    moves_d = '0;
                    head_d  = 1'b0;
                    left_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef LOOP_DETECT_EN
                    init_row_d = init_row;
                    init_col_d = init_col;
                    init_dir_d = dir_t'(init_dir);
`endif
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (sensor) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else if (max_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_SENSE_H;
                end
            end
            S_SENSE_H: begin
                head_d  = sensor;
                state_d = S_SENSE_L;
            end
            S_SENSE_L: begin
                left_d  = sensor;
                state_d = S_DRIVE;
            end
            S_DRIVE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                if (avancar && (girar || head_q)) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    if (avancar) begin
                        case (dir_q)
                            DIR_N: row_d = row_q - POS_W'(1);
                            DIR_S: row_d = row_q + POS_W'(1);
                            DIR_L: col_d = col_q + POS_W'(1);
                            DIR_O: col_d = col_q - POS_W'(1);
                            default: ;
                        endcase
                    end else if (girar) begin
                        case (dir_q)
                            DIR_N: dir_d = DIR_O;
                            DIR_O: dir_d = DIR_S;
                            DIR_S: dir_d = DIR_L;
                            DIR_L: dir_d = DIR_N;
                            default: ;
                        endcase
                    end
                    moves_d = moves_q + CNT_W'(1);
                    state_d = S_SENSE_H;
                    if (moves_d == max_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end
`ifdef LOOP_DETECT_EN
                    else if (row_d == init_row_q && col_d == init_col_q && dir_d == init_dir_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end
`endif
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            dir_q   <= DIR_N;
            max_q   <= '0;
            moves_q <= '0;
            head_q  <= 1'b0;
            left_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef LOOP_DETECT_EN
            init_row_q <= '0;
            init_col_q <= '0;
            init_dir_q <= DIR_N;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dir_q   <= dir_d;
            max_q   <= max_d;
            moves_q <= moves_d;
            head_q  <= head_d;
            left_q  <= left_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef LOOP_DETECT_EN
            init_row_q <= init_row_d;
            init_col_q <= init_col_d;
            init_dir_q <= init_dir_d;
`endif
        end
    end

    assign robot_step = (state_q == S_DRIVE);
    assign head       = head_q;
    assign left       = left_q;
    assign row        = row_q;
    assign col        = col_q;
    assign dir        = dir_q;
    assign moves      = moves_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_robo_step_sequencer.sv
// Scoreboard bench for robo_step_sequencer: per-step sensor expectations and per-run final results.
module tb_robo_step_sequencer;

    localparam int MS = 20;
    localparam int PW = 5;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] init_row = '0, init_col = '0;
    logic [1:0]    init_dir = '0;
    logic [CW-1:0] max_moves = '0;
    logic [PW-1:0] map_row, map_col, row, col;
    logic          map_wall, head, left, robot_step, avancar, girar, busy, done, error;
    logic [1:0]    dir;
    logic [CW-1:0] moves;

    logic wall [0:31][0:31];
    int   mode = 0;  // 0 advance, 1 turn, 2 both, 3 none

    assign map_wall = wall[map_row][map_col];
    assign avancar  = (mode == 0) || (mode == 2);
    assign girar    = (mode == 1) || (mode == 2);

    robo_step_sequencer #(.MAP_SIZE(MS), .POS_W(PW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .init_row(init_row), .init_col(init_col), .init_dir(init_dir), .max_moves(max_moves),
        .map_row(map_row), .map_col(map_col), .map_wall(map_wall),
        .head(head), .left(left), .robot_step(robot_step),
        .avancar(avancar), .girar(girar),
        .row(row), .col(col), .dir(dir), .moves(moves),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [PW-1:0] row, col;
        logic [1:0]    dir;
        logic [CW-1:0] moves;
        logic          done, error;
        int            steps, bcyc;
    } run_t;

    typedef struct {
        logic          head, left;
        logic [PW-1:0] row, col;
        logic [1:0]    dir;
    } step_t;

    run_t  run_q[$];
    step_t step_q[$];
    int    checks = 0;
    int    failures = 0;
    int    runs_seen = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_step(input logic h, input logic l, input int r, input int c, input int d);
        step_t s;
        s.head = h; s.left = l; s.row = PW'(r); s.col = PW'(c); s.dir = 2'(d);
        step_q.push_back(s);
    endtask

    task automatic push_run(input int r, input int c, input int d, input int m,
                            input logic dn, input logic er, input int st, input int bc);
        run_t x;
        x.row = PW'(r); x.col = PW'(c); x.dir = 2'(d); x.moves = CW'(m);
        x.done = dn; x.error = er; x.steps = st; x.bcyc = bc;
        run_q.push_back(x);
    endtask

    task automatic pulse_start(input int r, input int c, input int d, input int mx, input int md);
        @(negedge clock);
        mode      = md;
        init_row  = PW'(r);
        init_col  = PW'(c);
        init_dir  = 2'(d);
        max_moves = CW'(mx);
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic wait_run(input int target, input string nm);
        for (int i = 0; i < 2000 && runs_seen < target; i++) @(negedge clock);
        if (runs_seen < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got runs=%0d expected %0d", nm, runs_seen, target);
        end
    endtask

    task automatic do_run(input string nm, input int r, input int c, input int d, input int mx, input int md);
        int target;
        target = runs_seen + 1;
        pulse_start(r, c, d, mx, md);
        wait_run(target, nm);
    endtask

    // Monitor: one step expectation per robot_step pulse, one run expectation per busy fall.
    initial begin
        logic busy_prev;
        int   steps_cnt, bcyc;
        step_t s;
        run_t  x;
        busy_prev = 1'b0;
        steps_cnt = 0;
        bcyc      = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                busy_prev = 1'b0;
            end else begin
                if (busy && !busy_prev) begin
                    steps_cnt = 0;
                    bcyc      = 0;
                end
                if (busy) bcyc++;
                if (robot_step) begin
                    steps_cnt++;
                    if (step_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_step: got pulse expected none");
                    end else begin
                        s = step_q.pop_front();
                        chk("step_head", head, s.head);
                        chk("step_left", left, s.left);
                        chk("step_pose", {row, col, dir}, {s.row, s.col, s.dir});
                    end
                end
                if (!busy && busy_prev) begin
                    if (run_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_run: got run end expected none");
                    end else begin
                        x = run_q.pop_front();
                        chk("run_row", row, x.row);
                        chk("run_col", col, x.col);
                        chk("run_dir", dir, x.dir);
                        chk("run_moves", moves, x.moves);
                        chk("run_done", done, x.done);
                        chk("run_error", error, x.error);
                        chk("run_steps", steps_cnt, x.steps);
                        chk("run_busy_cycles", bcyc, x.bcyc);
                    end
                    runs_seen++;
                end
                busy_prev = busy;
            end
        end
    end

    initial begin
        int k;
        int target;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                wall[i][j] = 1'b0;
        wall[4][4] = 1'b1;

        #12;
        chk("reset_outputs", {map_row, map_col, head, left, robot_step, row, col, dir, moves, busy, done, error}, 0);
        @(negedge clock);
        reset = 1'b1;

        // Advance north three times in open space
        push_step(0, 0, 10, 10, 0); push_step(0, 0, 9, 10, 0); push_step(0, 0, 8, 10, 0);
        push_run(7, 10, 0, 3, 1, 0, 3, 13);
        do_run("adv_north", 10, 10, 0, 3, 0);

        // Top border: head reads wall, turn left to O
        push_step(1, 0, 1, 5, 0);
        push_run(1, 5, 3, 1, 1, 0, 1, 5);
        do_run("top_border", 1, 5, 0, 1, 1);

        // West border facing O, turn to S
        push_step(1, 0, 3, 1, 3);
        push_run(3, 1, 1, 1, 1, 0, 1, 5);
        do_run("west_border", 3, 1, 3, 1, 1);

        // Bottom-right corner facing L, turn to N
        push_step(1, 0, 20, 20, 2);
        push_run(20, 20, 0, 1, 1, 0, 1, 5);
        do_run("corner", 20, 20, 2, 1, 1);

        // Start on the wall cell
        push_run(4, 4, 0, 0, 0, 1, 0, 1);
        do_run("start_wall", 4, 4, 0, 3, 0);

        // Both commands together
        push_step(0, 0, 10, 10, 2);
        push_run(10, 10, 2, 0, 0, 1, 1, 5);
        do_run("both_cmds", 10, 10, 2, 5, 2);

        // Advance into the wall ahead
        push_step(1, 0, 5, 4, 0);
        push_run(5, 4, 0, 0, 0, 1, 1, 5);
        do_run("collision", 5, 4, 0, 3, 0);

        // Left sensor sees wall; robot idles (a move with no pose change)
        push_step(0, 1, 4, 3, 1);
`ifdef LOOP_DETECT_EN
        push_run(4, 3, 1, 1, 1, 0, 1, 5);
`else
        push_step(0, 1, 4, 3, 1);
        push_run(4, 3, 1, 2, 1, 0, 2, 9);
`endif
        do_run("idle_left_wall", 4, 3, 1, 2, 3);

        // Zero budget
        push_run(5, 5, 1, 0, 1, 0, 0, 1);
        do_run("zero_budget", 5, 5, 1, 0, 0);

        // Start while busy must be ignored
        push_step(0, 0, 10, 10, 1); push_step(0, 0, 11, 10, 1);
        push_run(12, 10, 1, 2, 1, 0, 2, 9);
        target = runs_seen + 1;
        pulse_start(10, 10, 1, 2, 0);
        repeat (3) @(negedge clock);
        init_row = 5'd2; init_col = 5'd2; max_moves = 8'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_run(target, "busy_start");
        repeat (5) @(negedge clock);
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_row", row, 12);

        // Reset during DRIVE
        pulse_start(10, 10, 0, 5, 0);
        k = 0;
        while (!robot_step && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("reach_drive", robot_step, 1);
        reset = 1'b0;
        #1;
        chk("midrun_robot_step", robot_step, 0);
        chk("midrun_outputs", {map_row, map_col, head, left, row, col, dir, moves, busy, done, error}, 0);
        @(negedge clock);
        reset = 1'b1;

        push_step(0, 0, 10, 10, 0); push_step(0, 0, 9, 10, 0); push_step(0, 0, 8, 10, 0);
        push_run(7, 10, 0, 3, 1, 0, 3, 13);
        do_run("after_reset", 10, 10, 0, 3, 0);

`ifdef LOOP_DETECT_EN
        push_step(0, 0, 10, 10, 0); push_step(0, 0, 10, 10, 3);
        push_step(0, 0, 10, 10, 1); push_step(0, 0, 10, 10, 2);
        push_run(10, 10, 0, 4, 1, 0, 4, 17);
        do_run("loop_detect", 10, 10, 0, 10, 1);
`endif

        repeat (3) @(negedge clock);
        chk("sb_steps_drained", step_q.size(), 0);
        chk("sb_runs_drained", run_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
